// File: rtl/clk_div_multi.sv
// Multi-channel programmable 50%-duty clock divider with per-channel tick strobes.
// Optional macro CLK_DIV_SYNC_EN adds a sync_start input that phase-aligns all enabled channels.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 24999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [3:0]        div_wr_ch,
  input  logic [CNT_W-1:0]  div_wr_data,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_start,
`endif
  output logic              div_wr_ack,
  output logic              div_wr_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       CH_LIMIT = 5'(NUM_CH);

  logic wr_ok;
  logic sync_go;

  assign wr_ok = ({1'b0, div_wr_ch} < CH_LIMIT);

`ifdef CLK_DIV_SYNC_EN
  assign sync_go = sync_start;
`else
  assign sync_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_wr_ack <= 1'b0;
      div_wr_err <= 1'b0;
    end else begin
      div_wr_ack <= div_wr & wr_ok;
      div_wr_err <= div_wr & ~wr_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(i);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] pend_nxt;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;

    assign wr_hit   = div_wr & wr_ok & (div_wr_ch == CH_IDX);
    // A write landing on a boundary cycle is picked up by div_act immediately.
    assign pend_nxt = wr_hit ? div_wr_data : div_pend;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt      <= '0;
        div_act  <= DIV_RST;
        div_pend <= DIV_RST;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        div_pend <= pend_nxt;
        if (!ch_en[i] || sync_go) begin
          cnt     <= '0;
          clk_q   <= 1'b0;
          tick_q  <= 1'b0;
          div_act <= pend_nxt;
        end else if (cnt == div_act) begin
          cnt     <= '0;
          clk_q   <= ~clk_q;
          tick_q  <= ~clk_q;
          div_act <= pend_nxt;
        end else begin
          cnt    <= cnt + CNT_ONE;
          tick_q <= 1'b0;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a half-period countdown model predicts every cycle's outputs.
// Honours CLK_DIV_SYNC_EN when the design is built with it.
module tb_clk_div_multi;

  localparam int NCH = 4;
  localparam int DEF = 24999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        div_wr;
  logic [3:0]  div_wr_ch;
  logic [23:0] div_wr_data;
  logic        sync_start;
  logic        div_wr_ack;
  logic        div_wr_err;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(24), .DEFAULT_DIV(DEF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .div_wr     (div_wr),
    .div_wr_ch  (div_wr_ch),
    .div_wr_data(div_wr_data),
`ifdef CLK_DIV_SYNC_EN
    .sync_start (sync_start),
`endif
    .div_wr_ack (div_wr_ack),
    .div_wr_err (div_wr_err),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] co;
    logic [3:0] tk;
    logic       ack;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: output level, cycles left in the current half-period,
  // active half-period divisor and pending divisor per channel.
  int m_lvl [NCH];
  int m_left[NCH];
  int m_act [NCH];
  int m_pend[NCH];

  task automatic model_step(output exp_t e);
    bit sy;
    e  = '0;
    sy = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    sy = sync_start;
`endif
    for (int i = 0; i < NCH; i++) begin
      int pn;
      bit tk;
      tk = 1'b0;
      pn = (div_wr && int'(div_wr_ch) == i) ? int'(div_wr_data) : m_pend[i];
      if (!rst_n) begin
        m_lvl[i] = 0; m_act[i] = DEF; m_pend[i] = DEF; m_left[i] = DEF + 1;
      end else begin
        m_pend[i] = pn;
        if (!ch_en[i] || sy) begin
          m_lvl[i] = 0; m_act[i] = pn; m_left[i] = pn + 1;
        end else begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_lvl[i]  = 1 - m_lvl[i];
            tk        = (m_lvl[i] == 1);
            m_act[i]  = pn;
            m_left[i] = pn + 1;
          end
        end
      end
      e.co[i] = (m_lvl[i] == 1);
      e.tk[i] = tk;
    end
    e.ack = rst_n && div_wr && (div_wr_ch < 4'd4);
    e.err = rst_n && div_wr && (div_wr_ch >= 4'd4);
  endtask

  task automatic cyc();
    exp_t e;
    model_step(e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = q.pop_front();
        chk("clk_out", clk_out, e.co);
        chk("tick", tick, e.tk);
        chk("div_wr_ack", {3'b0, div_wr_ack}, {3'b0, e.ack});
        chk("div_wr_err", {3'b0, div_wr_err}, {3'b0, e.err});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wr(input int ch, input int data);
    div_wr = 1'b1; div_wr_ch = 4'(ch); div_wr_data = 24'(data);
    cyc();
    div_wr = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NCH; i++) begin
      m_lvl[i] = 0; m_left[i] = DEF + 1; m_act[i] = DEF; m_pend[i] = DEF;
    end
    rst_n = 1'b0; ch_en = '0; div_wr = 1'b0; div_wr_ch = '0; div_wr_data = '0;
    sync_start = 1'b0;
    run(3);
    rst_n = 1'b1;

    // Default divisor on channel 0: first rise 25000 cycles after enable.
    ch_en = 4'b0001;
    run(25005);
    ch_en = 4'b0000;
    run(2);

    // ch1 at clk/2, ch2 with 4-cycle half-period, writes acknowledged.
    wr(1, 0);
    wr(2, 3);
    ch_en = 4'b0110;
    run(40);

    // ch0 at div=9, then shortened to 4 mid half-period.
    wr(0, 9);
    ch_en = 4'b0111;
    run(5);
    wr(0, 4);
    run(60);

    // Write exactly on the boundary cycle.
    n = 0;
    while (m_left[0] != 1 && n < 50) begin cyc(); n++; end
    checks++;
    if (m_left[0] != 1) begin
      errors++;
      $display("FAIL boundary_search: got no boundary expected one within 50 cycles");
    end
    wr(0, 2);
    run(30);

    // Out-of-range channel index is rejected.
    wr(7, 1);
    run(30);

    // Drop ch0 while high, then a one-cycle reset with ch1 running.
    n = 0;
    while (m_lvl[0] != 1 && n < 50) begin cyc(); n++; end
    ch_en = 4'b0110;
    run(4);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    ch_en = 4'b0001;
    run(25005);

    // Randomised traffic with small divisors.
    ch_en = 4'b1111;
    for (int i = 0; i < NCH; i++) wr(i, $urandom_range(0, 5));
    for (int k = 0; k < 3000; k++) begin
      div_wr      = ($urandom_range(0, 2) == 0);
      div_wr_ch   = 4'($urandom_range(0, 5));
      div_wr_data = 24'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) ch_en = ch_en ^ 4'($urandom_range(1, 15));
      rst_n       = ($urandom_range(0, 299) != 0);
      sync_start  = ($urandom_range(0, 99) == 0);
      cyc();
      if (!rst_n) begin
        rst_n = 1'b1;
        div_wr = 1'b0;
        for (int i = 0; i < NCH; i++) wr(i, $urandom_range(0, 7));
      end
    end
    div_wr = 1'b0;
    sync_start = 1'b0;
    run(5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
